dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: core port A and loader/debug port B share one
// single-cycle memory, with alternating tie-break and a bounded port-B lock.
module dmem_arbiter #(
  parameter int unsigned MAX_LOCK = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_req,
  input  logic       a_we,
  input  logic [7:0] a_addr,
  input  logic [7:0] a_wdata,
  output logic       a_ack,
  output logic       a_stall,
  output logic [7:0] a_rdata,
  input  logic       b_req,
  input  logic       b_we,
  input  logic [7:0] b_addr,
  input  logic [7:0] b_wdata,
  input  logic       b_lock,
  output logic       b_ack,
  output logic [7:0] b_rdata,
  output logic       mem_read,
  output logic       mem_write,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
);

  localparam logic [3:0] LockMax = 4'(MAX_LOCK);

  typedef enum logic [1:0] {StIdle, StServeA, StServeB} state_e;

  state_e     state_q, state_d;
  logic       last_b_q, last_b_d;
  logic [3:0] lock_q, lock_d;
  logic [7:0] a_rdata_q, b_rdata_q;
  logic       serve_a, serve_b, retain, prefer_b;

  always_comb begin
    serve_a   = (state_q == StServeA);
    serve_b   = (state_q == StServeB);
    retain    = serve_b & b_req & b_lock & (lock_q < LockMax);
    // The port being served right now counts as the most recent grant.
    prefer_b  = serve_a | (~serve_b & ~last_b_q);
    last_b_d  = serve_b | (~serve_a & last_b_q);

    state_d = StIdle;
    if (retain) begin
      state_d = StServeB;
    end else if (a_req && b_req) begin
      state_d = prefer_b ? StServeB : StServeA;
    end else if (a_req) begin
      state_d = StServeA;
    end else if (b_req) begin
      state_d = StServeB;
    end

    lock_d = lock_q;
    if (retain) begin
      lock_d = lock_q + 4'd1;
    end else if (state_d != StServeB || !b_lock) begin
      lock_d = '0;
    end

    a_ack     = serve_a;
    b_ack     = serve_b;
    a_stall   = a_req & ~serve_a;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (serve_a) begin
      mem_read  = ~a_we;
      mem_write = a_we;
      mem_addr  = a_addr;
      mem_wdata = a_wdata;
    end else if (serve_b) begin
      mem_read  = ~b_we;
      mem_write = b_we;
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      last_b_q  <= 1'b1;
      lock_q    <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
      lock_q   <= lock_d;
      if (serve_a && !a_we) a_rdata_q <= mem_rdata;
      if (serve_b && !b_we) b_rdata_q <= mem_rdata;
    end
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule
